inference_sequencer: RTL and testbench

Top-level sequencer for the accelerator datapath: on a start request it fetches 8 weight rows from the SRAM buffer into the systolic array, streams a programmed number of input vectors through it, and counts activated outputs returning from the bias/activation pipeline. When all outputs have arrived, it commands the buffer to commit them and reports status and errors to the AHB subordinate. It fills the controller slot between `ahb_sub`, `sram_buffer` and `systolic_array`.

---
 rtl/inference_sequencer.sv | 168 ++++++++++++++++
 tb/tb_inference_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inference_sequencer.sv
// Controller between the AHB subordinate, SRAM buffer and systolic array: loads
// weight rows, streams input vectors, counts returning outputs and commits them.
module inference_sequencer #(
    parameter int ROWS    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            start,
    input  logic            float_in,
    input  logic [7:0]      num_inputs,
    input  logic            err_clear,
    output logic            get_weights,
    output logic            get_inputs,
    output logic            get_out,
    input  logic            data_ready,
    input  logic [63:0]     data,
    input  logic            out_done,
    output logic [ROWS-1:0] load,
    output logic [63:0]     input_value,
    output logic            input_valid,
    output logic            float,
    input  logic            output_valid_act,
    output logic [7:0]      status_reg,
    output logic [7:0]      err_reg
);

    localparam int                ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(ROWS - 1);
    localparam logic [7:0]        TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, W_REQ, W_WAIT, W_LOAD, I_REQ, I_WAIT, I_FEED, DRAIN, COMMIT, ERROR
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ROW_W-1:0]  row_reg;
    logic [7:0]        in_cnt_reg;
    logic [7:0]        out_cnt_reg;
    logic [7:0]        num_reg;
    logic [7:0]        wdog_reg;
    logic              done_reg;
    logic              done_next;
    logic [7:0]        err_set;
    logic              accept;
    logic              busy;
    logic              busy_next;
    logic              ova_busy;
    logic              overflow;
    logic              wd_state;
    logic              wd_expire;

    always_comb begin
        busy      = !(state_reg inside {IDLE, ERROR});
        ova_busy  = output_valid_act && busy;
        overflow  = ova_busy && (out_cnt_reg == num_reg);
        wd_state  = state_reg inside {W_WAIT, I_WAIT, DRAIN, COMMIT};
        wd_expire = wd_state && (wdog_reg == TIMEOUT_CNT) && !data_ready && !output_valid_act;

        state_next = state_reg;
        err_set    = 8'h00;
        accept     = 1'b0;

        case (state_reg)
            IDLE: begin
                // A start coinciding with err_clear is dropped.
                if (start && !err_clear) begin
                    if (num_inputs == 8'd0) begin
                        err_set[0] = 1'b1;
                        state_next = ERROR;
                    end else begin
                        accept     = 1'b1;
                        state_next = W_REQ;
                    end
                end
            end
            W_REQ:  state_next = W_WAIT;
            W_WAIT: if (data_ready) state_next = W_LOAD;
            W_LOAD: state_next = (row_reg == LAST_ROW) ? I_REQ : W_REQ;
            I_REQ:  state_next = I_WAIT;
            I_WAIT: if (data_ready) state_next = I_FEED;
            I_FEED: state_next = (in_cnt_reg + 8'd1 == num_reg) ? DRAIN : I_REQ;
            DRAIN:  if (out_cnt_reg == num_reg) state_next = COMMIT;
            COMMIT: if (out_done) state_next = IDLE;
            ERROR:  if (err_clear) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (busy) begin
            if (overflow) begin
                err_set[4] = 1'b1;
                state_next = ERROR;
            end else if (wd_expire) begin
                if (state_reg == DRAIN) err_set[2] = 1'b1;
                else                    err_set[1] = 1'b1;
                state_next = ERROR;
            end
            if (start && !err_clear) err_set[3] = 1'b1;
        end

        done_next = done_reg;
        if (accept)
            done_next = 1'b0;
        else if (state_reg == COMMIT && state_next == IDLE)
            done_next = 1'b1;
        busy_next = !(state_next inside {IDLE, ERROR});
    end

    // Strobes are derived from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg   <= IDLE;
            row_reg     <= '0;
            in_cnt_reg  <= 8'd0;
            out_cnt_reg <= 8'd0;
            num_reg     <= 8'd0;
            wdog_reg    <= 8'd0;
            done_reg    <= 1'b0;
            get_weights <= 1'b0;
            get_inputs  <= 1'b0;
            get_out     <= 1'b0;
            load        <= '0;
            input_value <= 64'd0;
            input_valid <= 1'b0;
            float       <= 1'b0;
            status_reg  <= 8'h00;
            err_reg     <= 8'h00;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;

            if (accept) begin
                num_reg     <= num_inputs;
                float       <= float_in;
                row_reg     <= '0;
                in_cnt_reg  <= 8'd0;
                out_cnt_reg <= 8'd0;
            end else begin
                if (state_reg == W_LOAD && state_next == W_REQ)
                    row_reg <= row_reg + 1'b1;
                if (state_reg == I_FEED && state_next == I_REQ)
                    in_cnt_reg <= in_cnt_reg + 8'd1;
                if (ova_busy)
                    out_cnt_reg <= out_cnt_reg + 8'd1;
            end

            if (state_next != state_reg || data_ready || output_valid_act)
                wdog_reg <= 8'd0;
            else if (wd_state)
                wdog_reg <= wdog_reg + 8'd1;
            else
                wdog_reg <= 8'd0;

            if ((state_next == W_LOAD || state_next == I_FEED) && state_reg != state_next)
                input_value <= data;

            get_weights <= (state_next == W_REQ);
            get_inputs  <= (state_next == I_REQ);
            get_out     <= (state_reg == DRAIN) && (state_next == COMMIT);
            load        <= (state_next == W_LOAD) ? (ROWS'(1) << row_reg) : '0;
            input_valid <= (state_next == I_FEED);
            status_reg  <= {5'b00000, (state_next == ERROR), done_next, busy_next};
            err_reg     <= (err_clear ? 8'h00 : err_reg) | err_set;
        end
    end

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed bench for inference_sequencer: SRAM/array responders run in the
// background while one initial block steps through the scenarios.
module tb_inference_sequencer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic        float_in;
    logic [7:0]  num_inputs;
    logic        err_clear;
    logic        get_weights, get_inputs, get_out;
    logic        data_ready;
    logic [63:0] data;
    logic        out_done;
    logic [7:0]  load;
    logic [63:0] input_value;
    logic        input_valid;
    logic        float;
    logic        output_valid_act;
    logic [7:0]  status_reg;
    logic [7:0]  err_reg;
    logic [92:0] all_out;

    int checks = 0;
    int errors = 0;

    int  gw_seen = 0, word_idx = 0, withhold_at = 0, ret_delay = 10;
    bit  done_en = 1'b1, inject_ova = 1'b0;
    int  load_cnt = 0, iv_cnt = 0, go_cnt = 0, gi_cnt = 0;
    logic [7:0]  load_log [16];
    logic [63:0] word_log [16];
    logic [63:0] iv_log   [16];
    int timers[$];

    always #5 clk = ~clk;

    assign all_out = {get_weights, get_inputs, get_out, input_valid, float,
                      load, input_value, status_reg, err_reg};

    inference_sequencer #(.ROWS(8), .TIMEOUT(255)) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .start            (start),
        .float_in         (float_in),
        .num_inputs       (num_inputs),
        .err_clear        (err_clear),
        .get_weights      (get_weights),
        .get_inputs       (get_inputs),
        .get_out          (get_out),
        .data_ready       (data_ready),
        .data             (data),
        .out_done         (out_done),
        .load             (load),
        .input_value      (input_value),
        .input_valid      (input_valid),
        .float            (float),
        .output_valid_act (output_valid_act),
        .status_reg       (status_reg),
        .err_reg          (err_reg)
    );

    function automatic logic [63:0] word_of(input int k);
        logic [31:0] kk;
        kk = k;
        return {32'hCAFE_0000 + kk, 32'h0BAD_F00D ^ kk};
    endfunction

    task automatic check(input string tag, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s", tag);
        end else begin
            $display("PASS %s", tag);
        end
    endtask

    // SRAM buffer: answers each request one cycle later unless told to withhold.
    initial begin
        bit req;
        data_ready = 1'b0;
        data = 64'd0;
        forever begin
            @(negedge clk);
            req = 1'b0;
            if (get_weights) begin
                gw_seen++;
                req = !(withhold_at != 0 && gw_seen == withhold_at);
            end
            if (get_inputs) req = 1'b1;
            @(posedge clk);
            #1;
            data_ready = req;
            data = req ? word_of(word_idx) : 64'd0;
            if (req) word_idx++;
        end
    end

    initial begin
        bit od;
        out_done = 1'b0;
        forever begin
            @(negedge clk);
            od = get_out && done_en;
            @(posedge clk);
            #1;
            out_done = od;
        end
    end

    // Activation pipeline: one output ret_delay cycles after each feed.
    initial begin
        bit fire;
        output_valid_act = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            fire = inject_ova;
            inject_ova = 1'b0;
            for (int i = timers.size() - 1; i >= 0; i--) begin
                timers[i] = timers[i] - 1;
                if (timers[i] <= 0) begin
                    fire = 1'b1;
                    timers.delete(i);
                end
            end
            output_valid_act = fire;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (load != 8'h00) begin
                if (load_cnt < 16) begin
                    load_log[load_cnt] = load;
                    word_log[load_cnt] = input_value;
                end
                load_cnt++;
                $display("load strobe %0d: load=%02h word=%016h", load_cnt, load, input_value);
            end
            if (input_valid) begin
                if (iv_cnt < 16) iv_log[iv_cnt] = input_value;
                iv_cnt++;
                timers.push_back(ret_delay);
                $display("input feed %0d: word=%016h", iv_cnt, input_value);
            end
            if (get_out) go_cnt++;
            if (get_inputs) gi_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic [7:0] n, input logic f);
        @(posedge clk);
        #1;
        start = 1'b1;
        num_inputs = n;
        float_in = f;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1;
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int i;
        i = 0;
        while (status_reg[0] && i < limit) begin
            tick();
            i++;
        end
    endtask

    task automatic clear_mon();
        load_cnt = 0;
        iv_cnt = 0;
        go_cnt = 0;
        gi_cnt = 0;
        gw_seen = 0;
    endtask

    initial begin
        int i;
        int fbad;
        n_rst = 1'b0;
        start = 1'b0;
        float_in = 1'b0;
        num_inputs = 8'd0;
        err_clear = 1'b0;
        #3;
        check("reset_outputs", all_out === 93'd0);
        #20;
        n_rst = 1'b1;
        tick();
        tick();
        check("idle_status", status_reg === 8'h00);

        // Zero-length start
        clear_mon();
        pulse_start(8'd0, 1'b0);
        tick();
        check("zl_err", err_reg === 8'h01);
        check("zl_status", status_reg === 8'h04);
        repeat (3) tick();
        check("zl_no_requests", (gw_seen + gi_cnt) == 0);
        pulse_clear();
        tick();
        check("zl_clear_err", err_reg === 8'h00);
        check("zl_clear_status", status_reg === 8'h00);

        // Nominal run, three vectors
        clear_mon();
        word_idx = 0;
        ret_delay = 10;
        pulse_start(8'd3, 1'b0);
        tick();
        check("nom_busy", status_reg === 8'h01);
        wait_idle(400);
        check("nom_status", status_reg === 8'h02);
        check("nom_err", err_reg === 8'h00);
        check("nom_load_count", load_cnt == 8);
        check("nom_weight_reqs", gw_seen == 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("nom_load_onehot_%0d", k), load_log[k] === (8'h01 << k));
            check($sformatf("nom_load_word_%0d", k), word_log[k] === word_of(k));
        end
        check("nom_feed_count", iv_cnt == 3);
        for (int j = 0; j < 3; j++)
            check($sformatf("nom_feed_word_%0d", j), iv_log[j] === word_of(8 + j));
        check("nom_get_out", go_cnt == 1);

        // Withheld data after the third weight request
        clear_mon();
        withhold_at = 3;
        pulse_start(8'd2, 1'b0);
        i = 0;
        while (gw_seen < 3 && i < 100) begin
            tick();
            i++;
        end
        check("wh_third_req", gw_seen == 3);
        repeat (200) tick();
        check("wh_pending_err", err_reg === 8'h00);
        check("wh_pending_status", status_reg === 8'h01);
        i = 0;
        while (!status_reg[2] && i < 100) begin
            tick();
            i++;
        end
        check("wh_err", err_reg === 8'h02);
        check("wh_status", status_reg === 8'h04);
        repeat (3) tick();
        check("wh_loads", load_cnt == 2);
        pulse_clear();
        withhold_at = 0;
        tick();
        check("wh_clear", err_reg === 8'h00);

        // Early outputs that arrive while still feeding, clean completion
        clear_mon();
        ret_delay = 1;
        pulse_start(8'd2, 1'b0);
        wait_idle(300);
        check("ec_status", status_reg === 8'h02);
        check("ec_err", err_reg === 8'h00);
        check("ec_feeds", iv_cnt == 2);
        check("ec_get_out", go_cnt == 1);

        // Same stimulus plus one extra output during COMMIT
        clear_mon();
        done_en = 1'b0;
        pulse_start(8'd2, 1'b0);
        i = 0;
        while (go_cnt < 1 && i < 300) begin
            tick();
            i++;
        end
        check("eo_get_out", go_cnt == 1);
        check("eo_status_commit", status_reg === 8'h01);
        inject_ova = 1'b1;
        tick();
        tick();
        check("eo_err", err_reg === 8'h10);
        check("eo_status", status_reg === 8'h04);
        pulse_clear();
        done_en = 1'b1;
        tick();
        check("eo_clear", err_reg === 8'h00);

        // Second start while waiting for an input word
        clear_mon();
        ret_delay = 10;
        pulse_start(8'd2, 1'b0);
        i = 0;
        while (gi_cnt < 1 && i < 100) begin
            tick();
            i++;
        end
        check("sb_get_inputs", gi_cnt == 1);
        pulse_start(8'd5, 1'b0);
        tick();
        check("sb_err", err_reg === 8'h08);
        check("sb_busy", status_reg === 8'h01);
        wait_idle(400);
        check("sb_status", status_reg === 8'h02);
        check("sb_err_sticky", err_reg === 8'h08);
        check("sb_feeds", iv_cnt == 2);
        pulse_clear();
        tick();

        // Reset while draining, then a float-mode run
        clear_mon();
        pulse_start(8'd1, 1'b1);
        i = 0;
        while (iv_cnt < 1 && i < 200) begin
            tick();
            i++;
        end
        repeat (3) tick();
        check("rd_busy", status_reg === 8'h01);
        check("rd_float", float === 1'b1);
        n_rst = 1'b0;
        #1;
        check("rd_outputs_zero", all_out === 93'd0);
        tick();
        timers.delete();
        tick();
        n_rst = 1'b1;
        tick();
        check("rd_idle", status_reg === 8'h00);

        clear_mon();
        pulse_start(8'd1, 1'b1);
        fbad = 0;
        i = 0;
        while (status_reg[0] && i < 400) begin
            if (float !== 1'b1) fbad++;
            tick();
            i++;
        end
        check("fr_float_steady", fbad == 0);
        check("fr_status", status_reg === 8'h02);
        check("fr_err", err_reg === 8'h00);
        check("fr_feeds", iv_cnt == 1);
        check("fr_float_kept", float === 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
